// File: rtl/rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync_ctrl
// Description : Serial receive alignment/synchronisation controller. Hunts the
//               MSB-first bit stream for the COM symbol at any bit offset,
//               locks word boundaries after LOCK_COUNT aligned COMs, strobes
//               aligned bytes while locked and drops lock after MAX_GAP
//               consecutive non-COM words.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync_ctrl #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         MAX_GAP    = 16
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic       active,
  output logic       valid,
  output logic       word_strobe,
  output logic [7:0] word_out,
  output logic [2:0] bit_cnt,
  output logic [1:0] sync_state
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [CW-1:0] c_lock    = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] c_com_one = CW'(1);
  localparam logic [GW-1:0] c_gap_max = GW'(MAX_GAP);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_COUNT   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t          r_state,   w_state;
  logic [7:0]      r_win;
  logic [CW-1:0]   r_com_cnt, w_com_cnt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt;
  logic [2:0]      r_bit_cnt, w_bit_cnt;
  logic [7:0]      r_word,    w_word;
  logic            r_strobe,  w_strobe;
  logic            r_valid,   w_valid;
  logic            r_active,  w_active;

  logic [7:0]      w_nxt;
  logic            w_boundary;
  logic            w_com;
  logic [CW-1:0]   w_com_inc;
  logic [GW-1:0]   w_gap_inc;

  // Next-state and registered-output decode for the alignment FSM
  always_comb begin
    w_nxt      = {r_win[6:0], data_in};
    w_boundary = (r_bit_cnt == 3'd7);
    w_com      = (w_nxt == COM_SYMBOL);
    // COM counter saturates at the lock threshold rather than wrapping
    w_com_inc  = (r_com_cnt == c_lock) ? r_com_cnt : r_com_cnt + 1'b1;
    w_gap_inc  = r_gap_cnt + 1'b1;

    w_state    = r_state;
    w_com_cnt  = r_com_cnt;
    w_gap_cnt  = r_gap_cnt;
    w_bit_cnt  = r_bit_cnt + 3'd1;
    w_word     = r_word;
    w_strobe   = 1'b0;
    w_valid    = 1'b0;
    w_active   = r_active;

    case (r_state)
      ST_SEARCH: begin
        // Bit position is meaningless until a COM has been seen
        w_bit_cnt = 3'd0;
        w_active  = 1'b0;
        if (w_com) begin
          w_com_cnt = c_com_one;
          if (LOCK_COUNT == 1) begin
            w_state   = ST_ACTIVE;
            w_active  = 1'b1;
            w_gap_cnt = '0;
          end else begin
            w_state = ST_COUNT;
          end
        end
      end

      ST_COUNT: begin
        if (w_boundary) begin
          if (w_com) begin
            w_com_cnt = w_com_inc;
            if (w_com_inc == c_lock) begin
              // The locking COM itself is consumed here and not strobed
              w_state   = ST_ACTIVE;
              w_active  = 1'b1;
              w_gap_cnt = '0;
            end
          end else begin
            w_com_cnt = '0;
            w_state   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (w_boundary) begin
          w_strobe = 1'b1;
          w_word   = w_nxt;
          w_valid  = !w_com;
          if (w_com) begin
            w_gap_cnt = '0;
          end else if (w_gap_inc == c_gap_max) begin
            // Last tolerated word is still delivered on the same edge lock drops
            w_gap_cnt = '0;
            w_com_cnt = '0;
            w_state   = ST_SEARCH;
            w_active  = 1'b0;
          end else begin
            w_gap_cnt = w_gap_inc;
          end
        end
      end

      default: begin
        // Unreachable encoding: return to a clean SEARCH with outputs cleared
        w_state   = ST_SEARCH;
        w_com_cnt = '0;
        w_gap_cnt = '0;
        w_bit_cnt = 3'd0;
        w_word    = 8'h00;
        w_active  = 1'b0;
      end
    endcase
  end

  // State, counters, shift window and registered outputs
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= ST_SEARCH;
      r_win     <= 8'h00;
      r_com_cnt <= '0;
      r_gap_cnt <= '0;
      r_bit_cnt <= 3'd0;
      r_word    <= 8'h00;
      r_strobe  <= 1'b0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_win     <= w_nxt;
      r_com_cnt <= w_com_cnt;
      r_gap_cnt <= w_gap_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_word    <= w_word;
      r_strobe  <= w_strobe;
      r_valid   <= w_valid;
      r_active  <= w_active;
    end
  end

  assign active      = r_active;
  assign valid       = r_valid;
  assign word_strobe = r_strobe;
  assign word_out    = r_word;
  assign bit_cnt     = r_bit_cnt;
  assign sync_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_sync_ctrl
// Description : Directed self-checking bench for rx_sync_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_sync_ctrl;

  logic       clk_32f;
  logic       reset_L;
  logic       data_in;
  logic       active;
  logic       valid;
  logic       word_strobe;
  logic [7:0] word_out;
  logic [2:0] bit_cnt;
  logic [1:0] sync_state;

  int n_chk;
  int n_pass;
  int s_cnt;
  int v_cnt;
  int bad_bc;
  logic [7:0] s_word;
  logic       s_valid;

  rx_sync_ctrl #(
    .COM_SYMBOL (8'hBC),
    .LOCK_COUNT (4),
    .MAX_GAP    (16)
  ) u_dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .active      (active),
    .valid       (valid),
    .word_strobe (word_strobe),
    .word_out    (word_out),
    .bit_cnt     (bit_cnt),
    .sync_state  (sync_state)
  );

  // 10 ns bit clock
  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr_mon();
    s_cnt   = 0;
    v_cnt   = 0;
    bad_bc  = 0;
    s_word  = 8'h00;
    s_valid = 1'b0;
  endtask

  // Drive one bit, clock it in, then record any strobe seen after the edge
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    if (word_strobe) begin
      s_cnt++;
      s_word  = word_out;
      s_valid = valid;
      if (valid) v_cnt++;
      if (bit_cnt != 3'd0) bad_bc++;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Asynchronous reset pulse taken between clock edges
  task automatic pulse_reset();
    data_in = 1'b0;
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    data_in = 1'b0;
    reset_L = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk_32f);
    #1;
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_strobe", {31'd0, word_strobe}, 32'd0);
    chk("rst_word", {24'd0, word_out}, 32'd0);
    chk("rst_bitcnt", {29'd0, bit_cnt}, 32'd0);
    chk("rst_state", {30'd0, sync_state}, 32'd0);
    reset_L = 1'b1;

    // T1: lock on four aligned COMs, then one data byte
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    chk("t1_count_state", {30'd0, sync_state}, 32'd1);
    chk("t1_count_active", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    chk("t1_lock_active", {31'd0, active}, 32'd1);
    chk("t1_lock_state", {30'd0, sync_state}, 32'd2);
    chk("t1_no_com_strobe", s_cnt, 32'd0);
    send_byte(8'hAA);
    chk("t1_strobes", s_cnt, 32'd1);
    chk("t1_word", {24'd0, s_word}, 32'h0000_00AA);
    chk("t1_valid", {31'd0, s_valid}, 32'd1);
    chk("t1_bitcnt", bad_bc, 32'd0);
    send_bit(1'b0);
    chk("t1_strobe_pulse", {31'd0, word_strobe}, 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    // finish a realigned byte: previous 7 bits 0101010 plus final 1 -> 0x55
    send_bit(1'b1);
    chk("t1_next_word", {24'd0, word_out}, 32'h0000_0055);

    // T2: idle COM while locked clears the gap count and is not valid
    clr_mon();
    send_byte(8'hBC);
    chk("t2_strobes", s_cnt, 32'd1);
    chk("t2_word", {24'd0, s_word}, 32'h0000_00BC);
    chk("t2_valid", {31'd0, s_valid}, 32'd0);
    chk("t2_active", {31'd0, active}, 32'd1);

    // T5: sixteen non-COM words drop the lock on the sixteenth
    clr_mon();
    for (int k = 0; k < 15; k++) send_byte(8'h55);
    chk("t5_active_15", {31'd0, active}, 32'd1);
    send_byte(8'h55);
    chk("t5_strobes", s_cnt, 32'd16);
    chk("t5_valids", v_cnt, 32'd16);
    chk("t5_last_word", {24'd0, s_word}, 32'h0000_0055);
    chk("t5_active", {31'd0, active}, 32'd0);
    chk("t5_state", {30'd0, sync_state}, 32'd0);

    // T3: misaligned entry, three stray bits before the COMs
    pulse_reset();
    clr_mon();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    chk("t3_active", {31'd0, active}, 32'd1);
    send_byte(8'hAA);
    chk("t3_strobes", s_cnt, 32'd1);
    chk("t3_word", {24'd0, s_word}, 32'h0000_00AA);
    chk("t3_bitcnt", bad_bc, 32'd0);

    // T4: broken COM run returns to SEARCH, then a full run locks
    pulse_reset();
    clr_mon();
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    send_byte(8'hAA);
    chk("t4_search_state", {30'd0, sync_state}, 32'd0);
    chk("t4_no_strobe", s_cnt, 32'd0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    chk("t4_not_yet", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    chk("t4_relock", {31'd0, active}, 32'd1);
    chk("t4_relock_state", {30'd0, sync_state}, 32'd2);

    // T6: asynchronous reset in the middle of a word while locked
    send_byte(8'hAA);
    chk("t6_word_pre", {24'd0, word_out}, 32'h0000_00AA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t6_bitcnt_pre", {29'd0, bit_cnt}, 32'd3);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_active", {31'd0, active}, 32'd0);
    chk("t6_word", {24'd0, word_out}, 32'd0);
    chk("t6_bitcnt", {29'd0, bit_cnt}, 32'd0);
    chk("t6_state", {30'd0, sync_state}, 32'd0);
    @(posedge clk_32f);
    #1;
    data_in = 1'b0;
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    chk("t6_relock", {31'd0, active}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
